// File: rtl/ecc_66_rd_stage.sv
// Read-return stage behind the 66-bit SECDED checker: a 2-entry skid buffer for
// corrected words, plus saturating error counters, first-error capture and an interrupt.
module ecc_66_rd_stage #(
    parameter int ADDR_WIDTH = 6,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_vld,
    output logic                  in_rdy,
    input  logic [65:0]           in_data,
    input  logic                  in_sbit_err,
    input  logic                  in_dbit_err,
    input  logic [ADDR_WIDTH-1:0] in_addr,
    output logic                  out_vld,
    input  logic                  out_rdy,
    output logic [65:0]           out_data,
    output logic                  out_poison,
    input  logic                  cnt_clr,
    input  logic                  irq_sbit_en,
    output logic [CNT_WIDTH-1:0]  sbit_cnt,
    output logic [CNT_WIDTH-1:0]  dbit_cnt,
    output logic [ADDR_WIDTH-1:0] err_addr,
    output logic                  err_addr_vld,
    output logic                  err_type,
    output logic                  irq
);

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_ONE,
        ST_FULL
    } state_t;

    state_t state, state_nxt;

    logic [65:0] main_data, skid_data;
    logic        main_poison, skid_poison;
    logic        in_rdy_q, in_rdy_nxt;
    logic        accept;
    logic        load_main_in, load_main_skid, load_skid;

    logic        is_dbit, is_sbit;
    logic [CNT_WIDTH-1:0]  sbit_cnt_q, sbit_cnt_nxt;
    logic [CNT_WIDTH-1:0]  dbit_cnt_q, dbit_cnt_nxt;
    logic [ADDR_WIDTH-1:0] err_addr_q, err_addr_nxt;
    logic                  err_vld_q, err_vld_nxt;
    logic                  err_type_q, err_type_nxt;
    logic                  cap_vld_base, cap_type_base;

    assign accept  = in_vld & in_rdy_q;
    assign is_dbit = in_dbit_err;
    assign is_sbit = in_sbit_err & ~in_dbit_err;

    // Skid buffer control: in_rdy is registered from the next state so it
    // never depends combinationally on out_rdy.
    always_comb begin
        state_nxt      = state;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        case (state)
            ST_EMPTY: begin
                if (accept) begin
                    load_main_in = 1'b1;
                    state_nxt    = ST_ONE;
                end
            end
            ST_ONE: begin
                if (accept && out_rdy) begin
                    load_main_in = 1'b1;
                end else if (accept) begin
                    load_skid = 1'b1;
                    state_nxt = ST_FULL;
                end else if (out_rdy) begin
                    state_nxt = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (out_rdy) begin
                    load_main_skid = 1'b1;
                    state_nxt      = ST_ONE;
                end
            end
            default: state_nxt = ST_EMPTY;
        endcase
        in_rdy_nxt = (state_nxt != ST_FULL);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_EMPTY;
            in_rdy_q    <= 1'b1;
            main_data   <= '0;
            main_poison <= 1'b0;
            skid_data   <= '0;
            skid_poison <= 1'b0;
        end else begin
            state    <= state_nxt;
            in_rdy_q <= in_rdy_nxt;
            if (load_main_in) begin
                main_data   <= in_data;
                main_poison <= in_dbit_err;
            end else if (load_main_skid) begin
                main_data   <= skid_data;
                main_poison <= skid_poison;
            end
            if (load_skid) begin
                skid_data   <= in_data;
                skid_poison <= in_dbit_err;
            end
        end
    end

    // A clear takes effect first, so an error beat in the same cycle counts
    // as 1 and becomes the fresh capture.
    always_comb begin
        sbit_cnt_nxt = cnt_clr ? '0 : sbit_cnt_q;
        dbit_cnt_nxt = cnt_clr ? '0 : dbit_cnt_q;
        if (accept && is_sbit && !(&sbit_cnt_nxt)) begin
            sbit_cnt_nxt = sbit_cnt_nxt + CNT_WIDTH'(1);
        end
        if (accept && is_dbit && !(&dbit_cnt_nxt)) begin
            dbit_cnt_nxt = dbit_cnt_nxt + CNT_WIDTH'(1);
        end

        cap_vld_base  = cnt_clr ? 1'b0 : err_vld_q;
        cap_type_base = cnt_clr ? 1'b0 : err_type_q;
        err_addr_nxt  = cnt_clr ? '0 : err_addr_q;
        err_vld_nxt   = cap_vld_base;
        err_type_nxt  = cap_type_base;
        if (accept && (is_sbit || is_dbit)) begin
            if (!cap_vld_base || (is_dbit && !cap_type_base)) begin
                err_addr_nxt = in_addr;
                err_vld_nxt  = 1'b1;
                err_type_nxt = is_dbit;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sbit_cnt_q <= '0;
            dbit_cnt_q <= '0;
            err_addr_q <= '0;
            err_vld_q  <= 1'b0;
            err_type_q <= 1'b0;
        end else begin
            sbit_cnt_q <= sbit_cnt_nxt;
            dbit_cnt_q <= dbit_cnt_nxt;
            err_addr_q <= err_addr_nxt;
            err_vld_q  <= err_vld_nxt;
            err_type_q <= err_type_nxt;
        end
    end

    assign in_rdy       = in_rdy_q;
    assign out_vld      = (state != ST_EMPTY);
    assign out_data     = main_data;
    assign out_poison   = main_poison;
    assign sbit_cnt     = sbit_cnt_q;
    assign dbit_cnt     = dbit_cnt_q;
    assign err_addr     = err_addr_q;
    assign err_addr_vld = err_vld_q;
    assign err_type     = err_type_q;
    assign irq          = err_vld_q & (err_type_q | irq_sbit_en);

endmodule

// File: tb/tb_ecc_66_rd_stage.sv
// Bench for ecc_66_rd_stage: directed and random beats compared cycle by cycle
// against a queue-based model of the buffer, counters and error capture.
module tb_ecc_66_rd_stage;

    localparam int AW      = 6;
    localparam int CW      = 4;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic          clk, rst;
    logic          in_vld, in_rdy;
    logic [65:0]   in_data;
    logic          in_sbit_err, in_dbit_err;
    logic [AW-1:0] in_addr;
    logic          out_vld, out_rdy;
    logic [65:0]   out_data;
    logic          out_poison;
    logic          cnt_clr, irq_sbit_en;
    logic [CW-1:0] sbit_cnt, dbit_cnt;
    logic [AW-1:0] err_addr;
    logic          err_addr_vld, err_type, irq;

    ecc_66_rd_stage #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst),
        .in_vld(in_vld), .in_rdy(in_rdy), .in_data(in_data),
        .in_sbit_err(in_sbit_err), .in_dbit_err(in_dbit_err), .in_addr(in_addr),
        .out_vld(out_vld), .out_rdy(out_rdy), .out_data(out_data), .out_poison(out_poison),
        .cnt_clr(cnt_clr), .irq_sbit_en(irq_sbit_en),
        .sbit_cnt(sbit_cnt), .dbit_cnt(dbit_cnt),
        .err_addr(err_addr), .err_addr_vld(err_addr_vld), .err_type(err_type), .irq(irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [65:0] data;
        logic        poison;
    } beat_t;

    beat_t         m_q[$];
    int            m_scnt, m_dcnt;
    logic [AW-1:0] m_addr;
    logic          m_cap_vld, m_cap_type;

    int checks = 0;
    int errors = 0;
    int dut_accepts = 0;

    function automatic logic [65:0] rand66();
        logic [31:0] r0, r1, r2;
        r0 = $urandom;
        r1 = $urandom;
        r2 = $urandom;
        return {r2[1:0], r1, r0};
    endfunction

    task automatic check(input string tag, input logic [65:0] obs, input logic [65:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_scnt     = 0;
        m_dcnt     = 0;
        m_addr     = '0;
        m_cap_vld  = 1'b0;
        m_cap_type = 1'b0;
    endtask

    // Behaviour at one rising edge, from the current inputs and model state.
    task automatic model_step();
        bit    acc, dbit, sbit;
        beat_t b;
        acc  = in_vld && (m_q.size() < 2);
        dbit = in_dbit_err;
        sbit = in_sbit_err && !in_dbit_err;
        if (m_q.size() > 0 && out_rdy) void'(m_q.pop_front());
        if (acc) begin
            b.data   = in_data;
            b.poison = in_dbit_err;
            m_q.push_back(b);
        end
        if (cnt_clr) begin
            m_scnt = 0; m_dcnt = 0;
            m_cap_vld = 1'b0; m_cap_type = 1'b0; m_addr = '0;
        end
        if (acc && sbit) m_scnt = (m_scnt + 1 > CNT_MAX) ? CNT_MAX : m_scnt + 1;
        if (acc && dbit) m_dcnt = (m_dcnt + 1 > CNT_MAX) ? CNT_MAX : m_dcnt + 1;
        if (acc && (sbit || dbit) && (!m_cap_vld || (dbit && !m_cap_type))) begin
            m_cap_vld  = 1'b1;
            m_cap_type = dbit;
            m_addr     = in_addr;
        end
    endtask

    task automatic checkOutput();
        check("in_rdy", 66'(in_rdy), 66'(m_q.size() < 2));
        check("out_vld", 66'(out_vld), 66'(m_q.size() > 0));
        if (m_q.size() > 0) begin
            check("out_data", out_data, m_q[0].data);
            check("out_poison", 66'(out_poison), 66'(m_q[0].poison));
        end
        check("sbit_cnt", 66'(sbit_cnt), 66'(m_scnt));
        check("dbit_cnt", 66'(dbit_cnt), 66'(m_dcnt));
        check("err_addr_vld", 66'(err_addr_vld), 66'(m_cap_vld));
        check("err_type", 66'(err_type), 66'(m_cap_type));
        check("err_addr", 66'(err_addr), 66'(m_addr));
        check("irq", 66'(irq), 66'(m_cap_vld & (m_cap_type | irq_sbit_en)));
    endtask

    task automatic applyStimulus(input logic vld, input logic [65:0] d, input logic s,
                                 input logic db, input logic [AW-1:0] a,
                                 input logic ordy, input logic clr);
        in_vld      = vld;
        in_data     = d;
        in_sbit_err = s;
        in_dbit_err = db;
        in_addr     = a;
        out_rdy     = ordy;
        cnt_clr     = clr;
        if (in_vld && in_rdy) dut_accepts++;
        @(posedge clk);
        model_step();
        #1;
        checkOutput();
    endtask

    task automatic idle(input int n, input logic ordy);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, ordy, 1'b0);
    endtask

    task automatic check_reset_state();
        check("rst_out_data", out_data, 66'h0);
        check("rst_out_poison", 66'(out_poison), 66'h0);
        check("rst_out_vld", 66'(out_vld), 66'h0);
        check("rst_in_rdy", 66'(in_rdy), 66'h1);
        check("rst_cnts", 66'({sbit_cnt, dbit_cnt}), 66'h0);
        check("rst_irq", 66'(irq), 66'h0);
    endtask

    initial begin
        logic [65:0] d;
        int          acc0;

        rst = 1'b1; in_vld = 0; in_data = '0; in_sbit_err = 0; in_dbit_err = 0;
        in_addr = '0; out_rdy = 0; cnt_clr = 0; irq_sbit_en = 0;
        model_reset();
        #2;
        check_reset_state();
        checkOutput();
        @(negedge clk);
        rst = 1'b0;

        // Streaming clean beats
        for (int i = 0; i < 32; i++) applyStimulus(1'b1, rand66(), 1'b0, 1'b0, AW'(i), 1'b1, 1'b0);
        idle(2, 1'b1);

        // Backpressure: only two beats fit
        acc0 = dut_accepts;
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, rand66(), 1'b0, 1'b0, AW'(i), 1'b0, 1'b0);
        check("bp_accepts", 66'(dut_accepts - acc0), 66'd2);
        check("bp_in_rdy", 66'(in_rdy), 66'h0);
        idle(3, 1'b1);

        // Error sequence with sbit interrupts masked
        irq_sbit_en = 1'b0;
        applyStimulus(1'b1, rand66(), 1'b1, 1'b0, 6'h05, 1'b1, 1'b0);
        applyStimulus(1'b1, rand66(), 1'b0, 1'b1, 6'h09, 1'b1, 1'b0);
        check("err_poison_09", 66'(out_poison), 66'h1);
        applyStimulus(1'b1, rand66(), 1'b1, 1'b0, 6'h0A, 1'b1, 1'b0);
        check("err_poison_0a", 66'(out_poison), 66'h0);
        idle(1, 1'b1);
        check("err_seq", 66'({sbit_cnt, dbit_cnt, err_addr, err_type, irq}),
              66'({4'd2, 4'd1, 6'h09, 1'b1, 1'b1}));

        // Saturation then clear with a concurrent sbit beat
        for (int i = 0; i < 20; i++) applyStimulus(1'b1, rand66(), 1'b1, 1'b0, AW'(i), 1'b1, 1'b0);
        check("sat_sbit", 66'(sbit_cnt), 66'd15);
        applyStimulus(1'b1, rand66(), 1'b1, 1'b0, 6'h11, 1'b1, 1'b1);
        check("clr_cap", 66'({sbit_cnt, dbit_cnt, err_addr, err_addr_vld, err_type}),
              66'({4'd1, 4'd0, 6'h11, 1'b1, 1'b0}));

        // Both flags on one beat count as dbit only
        applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, 1'b1, 1'b1);
        applyStimulus(1'b1, rand66(), 1'b1, 1'b1, 6'h03, 1'b1, 1'b0);
        check("both_flags", 66'({sbit_cnt, dbit_cnt, err_type}), 66'({4'd0, 4'd1, 1'b1}));

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            if (i % 50 == 0) irq_sbit_en = 1'($urandom_range(0, 1));
            applyStimulus(($urandom % 4) != 0, rand66(), ($urandom % 4) == 0,
                          ($urandom % 8) == 0, AW'($urandom), ($urandom % 3) != 0,
                          ($urandom % 40) == 0);
        end

        // Reset with two beats buffered
        idle(3, 1'b1);
        applyStimulus(1'b1, rand66(), 1'b1, 1'b0, 6'h01, 1'b0, 1'b0);
        applyStimulus(1'b1, rand66(), 1'b0, 1'b0, 6'h02, 1'b0, 1'b0);
        check("pre_rst_full", 66'(in_rdy), 66'h0);
        in_vld = 1'b0;
        rst = 1'b1;
        #1;
        model_reset();
        check_reset_state();
        checkOutput();
        @(negedge clk);
        rst = 1'b0;
        d = rand66();
        applyStimulus(1'b1, d, 1'b0, 1'b0, 6'h07, 1'b1, 1'b0);
        check("post_rst_vld", 66'(out_vld), 66'h1);
        check("post_rst_data", out_data, d);
        idle(2, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
